// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//   - Access-size encodings driven on the size port.
//   - FSM state encoding used by dmem_ctrl.
//   - access_fault(): decides whether an access is rejected (reserved size,
//     misalignment or an address beyond the populated array).
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // lane is addr[1:0]; out_of_range is precomputed by the caller because it
  // depends on the instance's depth.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [1:0] lane,
                                        input logic       out_of_range);
    logic f;
    f = out_of_range;
    case (size)
      SZ_H:    f = f | lane[0];
      SZ_W:    f = f | (lane != 2'b00);
      SZ_R:    f = 1'b1;
      default: f = f;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage for dmem_ctrl.
//   clk      : write clock
//   be       : per-byte write enables (bit n writes wdata[8n+7:8n])
//   waddr    : word index written on the rising edge when any be bit is set
//   wdata    : lane-aligned write data
//   raddr    : word index for the combinational read port
//   rdata    : mem[raddr], old contents during a write cycle
//   dbg_word : mem[DBG_WORD], combinational
// The array has no reset; it starts zeroed and then only changes by writes.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DBG_WORD    = 0,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  output logic [31:0]      dbg_word
);

  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata    = mem[raddr];
  assign dbg_word = mem[IDX_W'(DBG_WORD)];

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with a request/response handshake.
//   clk, rst   : clock, asynchronous active-high reset (control state only)
//   req        : request valid, accepted when ready is high at a rising edge
//   we         : 1 = store, 0 = load
//   size       : 00 byte, 01 halfword, 10 word, 11 reserved
//   sign_ext   : sign- (1) or zero- (0) extend byte/halfword loads
//   addr       : byte address
//   wdata      : right-aligned store data
//   ready      : low only while waiting out WAIT_CYCLES
//   resp_valid : one-cycle response strobe
//   rdata      : last successful load result, held between responses
//   err        : fault flag for the current response
//   dbg_word   : combinational view of word DBG_WORD
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1,
  parameter int DBG_WORD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [31:0]       dbg_word
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Place a byte or halfword of the stored word at bit 0 and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        sx);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] x_s;
    logic        [31:0] r;
    b   = word[8*lane +: 8];
    h   = lane[1] ? word[31:16] : word[15:0];
    b_s = signed'(b);
    h_s = signed'(h);
    case (sz)
      SZ_B: begin
        x_s = b_s;
        r   = sx ? unsigned'(x_s) : {24'h0, b};
      end
      SZ_H: begin
        x_s = h_s;
        r   = sx ? unsigned'(x_s) : {16'h0, h};
      end
      default: begin
        x_s = '0;
        r   = word;
      end
    endcase
    return r;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, commit;

  logic              we_p0, sx_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  logic              c_we, c_sx, c_oor, c_fault;
  logic [1:0]        c_size, lane;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata, wlanes, rword, ld_val;
  logic [3:0]        lane_be, be;

  // FSM outputs and next state
  always_comb begin
    state_nxt  = state;
    ready      = (state != ST_WAIT);
    resp_valid = (state == ST_RESP);
    case (state)
      ST_IDLE, ST_RESP: begin
        if (req && ready) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        else              state_nxt = ST_IDLE;
      end
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = req && ready;

  // The edge entering RESP is the commit edge. Gating with rst keeps a store
  // from landing while reset is held (with WAIT_CYCLES=0, IDLE still accepts).
  assign commit = !rst && (((state == ST_WAIT) && (cnt == 4'd0)) ||
                           ((WAIT_CYCLES == 0) && accept));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cnt <= 4'd0;
    else if (accept && (WAIT_CYCLES > 0))  cnt <= 4'(WAIT_CYCLES - 1);
    else if (state == ST_WAIT && cnt != 0) cnt <= cnt - 4'd1;
  end

  // p0: request captured at accept, used when the commit comes later
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= we;
      size_p0  <= size;
      sx_p0    <= sign_ext;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // With no wait states the commit edge is the accept edge, so the live
  // request is used directly.
  assign c_we    = (WAIT_CYCLES == 0) ? we       : we_p0;
  assign c_size  = (WAIT_CYCLES == 0) ? size     : size_p0;
  assign c_sx    = (WAIT_CYCLES == 0) ? sign_ext : sx_p0;
  assign c_addr  = (WAIT_CYCLES == 0) ? addr     : addr_p0;
  assign c_wdata = (WAIT_CYCLES == 0) ? wdata    : wdata_p0;

  assign lane    = c_addr[1:0];
  assign c_oor   = (32'(c_addr[ADDR_W-1:2]) >= 32'(DEPTH_WORDS));
  assign c_fault = access_fault(c_size, lane, c_oor);

  always_comb begin
    lane_be = 4'b0000;
    wlanes  = c_wdata;
    case (c_size)
      SZ_B: begin
        lane_be = 4'b0001 << lane;
        wlanes  = {4{c_wdata[7:0]}};
      end
      SZ_H: begin
        lane_be = lane[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{c_wdata[15:0]}};
      end
      SZ_W:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  assign be     = (commit && c_we && !c_fault) ? lane_be : 4'b0000;
  assign ld_val = load_extract(rword, c_size, lane, c_sx);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DBG_WORD   (DBG_WORD),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .be      (be),
    .waddr   (c_addr[IDX_W+1:2]),
    .wdata   (wlanes),
    .raddr   (c_addr[IDX_W+1:2]),
    .rdata   (rword),
    .dbg_word(dbg_word)
  );

  // p1: response registers, updated on the commit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'h0;
      err   <= 1'b0;
    end else if (commit) begin
      err <= c_fault;
      if (!c_fault && !c_we) rdata <= ld_val;
    end
  end

endmodule
